ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. LED set 0xED, enable 0xF4) to a keyboard or mouse over the shared open-drain PS/2 clock and data lines. It runs the full host request-to-send sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop, and device acknowledge. It sits beside the PS/2 receive decoder on the same pins and drives the lines only while `busy` is high, so the receiver never sees a transmit frame as keyboard data.

## Interface
- `CLK_FREQ`, 25_000_000: system clock in Hz (informational).
- `INHIBIT_CYCLES`, 2500: cycles the clock line is held low before the start bit (100 µs at 25 MHz).
- `TIMEOUT_CYCLES`, 375_000: watchdog limit in cycles (15 ms); used only when `PS2_TX_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `ps2_clk_in` in 1: raw PS/2 clock pin level (asynchronous).
- `ps2_data_in` in 1: raw PS/2 data pin level (asynchronous).
- `tx_data` in 8: byte to send; sampled when `tx_start` is accepted.
- `tx_start` in 1: one-cycle request; ignored while `busy`=1.
- `busy` out 1: high from the cycle after acceptance until the end-of-transaction pulse.
- `done` out 1: one-cycle pulse; device acknowledged.
- `error` out 1: one-cycle pulse; NACK or watchdog expiry.
- `ps2_clk_oe` out 1: 1 pulls the PS/2 clock low; 0 releases it.
- `ps2_data_oe` out 1: 1 pulls the PS/2 data low; 0 releases it.

## Operation
- Both pin inputs pass through 2-flop synchronizers. A falling edge is prev=1, cur=0 on the synchronized clock.
- Parity = ~^tx_data (odd parity). Frame register = {stop=1, parity, data[7:0]}. Bit counter is 4 bits, 0..10.
- States:
  - **IDLE**: both oe=0. An accepted `tx_start` latches the frame, clears the counters and moves to INHIBIT.
  - **INHIBIT**: `ps2_clk_oe`=1 for exactly INHIBIT_CYCLES cycles, then go to RTS.
  - **RTS**: `ps2_data_oe`=1 (start bit) and `ps2_clk_oe`=0 on entry. Wait for the first falling edge, which the device uses to sample the start bit, then go to SEND with bit=0.
  - **SEND**: on each falling edge, present frame[bit] as `ps2_data_oe`=~frame[bit] and increment bit. After the stop bit (bit index 9) is presented, `ps2_data_oe`=0; go to ACK.
  - **ACK**: on the next falling edge, sample synchronized data. 0 = ACK, 1 = NACK. Go to WAIT_IDLE.
  - **WAIT_IDLE**: wait until synchronized clock=1 and data=1. Then pulse `done` on ACK or `error` on NACK, and go to IDLE.
- Exactly one of `done`/`error` pulses per accepted request.
- `tx_start` while busy is dropped with no effect.
- A request in the same cycle as the end pulse is not accepted, because `busy` is still 1.

## Timing
- Reset values: `busy`=0, `done`=0, `error`=0, `ps2_clk_oe`=0, `ps2_data_oe`=0, state=IDLE.
- Reset mid-transaction releases both lines immediately (asynchronous) and discards the frame.
- `tx_start` at cycle N gives `busy`=1 and `ps2_clk_oe`=1 at N+1.
- `ps2_clk_oe` falls and `ps2_data_oe` rises in the same cycle, INHIBIT_CYCLES after entering INHIBIT.
- Pin-to-action latency is 3 cycles: 2 synchronizer stages plus edge detect. Data changes while the device clock is low; the device samples on the rising edge.
- `busy` falls in the cycle after the `done`/`error` pulse.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - A watchdog counts cycles in RTS, SEND, ACK and WAIT_IDLE, and is cleared on every falling edge.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse `error`, return to IDLE.
- Not defined: no watchdog logic; the block waits indefinitely for device clocks.

## Test plan
- Send 0xED with a device model that ACKs: clock held low 2500 cycles, then data bits 1,0,1,1,0,1,1,1, parity 1, stop 1 seen at the device → `done`=1 for one cycle, `error` never asserted.
- Send 0xF4: parity bit 0 seen at the device; ACK → `done`. Pulse `tx_start` with 0x00 mid-frame → ignored, and the frame continues to carry 0xF4.
- Device model leaves data high on the 11th clock (NACK) → `error` pulse only after lines are idle, `busy` falls the next cycle.
- Assert `reset` during SEND at bit 4 → both oe=0 and `busy`=0 asynchronously. The next `tx_start` of 0x01 completes normally with parity 0.
- With `PS2_TX_TIMEOUT_EN`, device never clocks after RTS → `error` exactly 375_000 cycles after entering RTS, both lines released.
- Without `PS2_TX_TIMEOUT_EN`, same stimulus → `busy` stays 1 and `ps2_data_oe` stays 1 for 1_000_000 cycles.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 11-bit frame, device ACK.
// Optional watchdog on stalled device clocking: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int CLK_FREQ       = 25_000_000,
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_RTS     = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_END     = 3'd6;

  localparam int               INH_W    = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  if (CLK_FREQ < 1 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ps2_host_tx: CLK_FREQ, INHIBIT_CYCLES and TIMEOUT_CYCLES must be positive");
  end

  // Pin synchronizers reset to the idle (released, pulled-up) level.
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;
  logic fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_data_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  logic [2:0]       state_q, state_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bit_q, bit_d;
  logic [INH_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    ack_d     = ack_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_start) begin
          frame_d  = {1'b1, ~^tx_data, tx_data};
          bit_d    = 4'd0;
          cnt_d    = '0;
          ack_d    = 1'b0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          cnt_d = cnt_q + INH_W'(1);
        end
      end
      // First device falling edge only clocks out the start bit already on the line.
      S_RTS: begin
        if (fall) begin
          bit_d   = 4'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (fall) begin
          data_oe_d = ~frame_q[bit_q];
          bit_d     = bit_q + 4'd1;
          if (bit_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) begin
          ack_d   = ~dat_sync_q;
          state_d = S_WAIT;
        end
      end
      // Report only once the device has let both lines float back high.
      S_WAIT: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d  = ack_q;
          error_d = ~ack_q;
          state_d = S_END;
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wd_d = wd_q;
    if (state_q == S_IDLE || state_q == S_INHIBIT || state_q == S_END || fall) begin
      wd_d = '0;
    end else if (wd_q == WD_LAST) begin
      wd_d      = '0;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b0;
      error_d   = 1'b1;
      state_d   = S_END;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_q     <= '0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`endif

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign error       = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Builds with or without PS2_TX_TIMEOUT_EN; the stall test adapts to the build.
module tb_ps2_host_tx;

  localparam int INH  = 2500;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, error, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_pin, ps2_data_pin;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  assign ps2_clk_pin  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_pin = ~ps2_data_oe & dev_dat;

  ps2_host_tx #(
    .CLK_FREQ(25_000_000), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .ps2_clk_in(ps2_clk_pin), .ps2_data_in(ps2_data_pin),
    .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done), .error(error),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)  done_cnt++;
    if (error) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Request a byte, check acceptance, measure clock inhibit; returns in the first RTS cycle.
  task automatic start_tx(input string tag, input logic [7:0] d);
    int n;
    @(negedge clk); tx_data = d; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    chk({tag, "_busy_n1"}, busy, 1);
    chk({tag, "_clk_oe_n1"}, ps2_clk_oe, 1);
    n = 1;
    while (n < 3000) begin
      @(negedge clk);
      if (!ps2_clk_oe) break;
      n++;
    end
    chk({tag, "_inhibit_len"}, n, INH);
    chk({tag, "_rts_data_oe"}, ps2_data_oe, 1);
  endtask

  // Device side: 12 clocks, samples on rising edges, drives ACK/NACK before clock 12.
  task automatic dev_frame(input string tag, input int glitch_k, input int rst_k,
                           input logic ack, output logic [10:0] bits);
    bits = '0;
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      dev_clk = 1'b0;
      if (k == glitch_k) begin
        @(negedge clk); tx_data = 8'h00; tx_start = 1'b1;
        @(negedge clk); tx_start = 1'b0;
        repeat (HALF - 2) @(negedge clk);
      end else if (k == rst_k) begin
        repeat (8) @(negedge clk);
        chk({tag, "_pre_rst_data_oe"}, ps2_data_oe, 1);
        chk({tag, "_pre_rst_busy"}, busy, 1);
        @(posedge clk); #2 reset = 1'b1; #1;
        chk({tag, "_rst_oe"}, {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk({tag, "_rst_busy"}, busy, 0);
        @(negedge clk); reset = 1'b0; dev_clk = 1'b1; dev_dat = 1'b1;
        return;
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk = 1'b1;
      if (k <= 11) bits[k-1] = ps2_data_pin;
      if (k == 11) dev_dat = ~ack;
      if (k == 12) begin
        dev_dat = 1'b1;
        return;
      end
      repeat (HALF) @(negedge clk);
    end
  endtask

  // Wait for the end pulse; optionally fire tx_start in the pulse cycle.
  task automatic wait_end(input string tag, input logic exp_done, input logic inject);
    int n;
    n = 0;
    while (!(done || error) && n < 400) begin
      @(negedge clk); n++;
    end
    chk({tag, "_pulse_seen"}, done | error, 1);
    if (!(done || error)) return;
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_error"}, error, !exp_done);
    chk({tag, "_idle_pins"}, {ps2_clk_pin, ps2_data_pin}, 2'b11);
    chk({tag, "_busy_at_pulse"}, busy, 1);
    if (inject) begin tx_data = 8'hAB; tx_start = 1'b1; end
    @(negedge clk); tx_start = 1'b0;
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_pulse_1cyc"}, {done, error}, 2'b00);
    @(negedge clk);
    chk({tag, "_stay_idle"}, {busy, ps2_clk_oe, ps2_data_oe}, 3'b000);
  endtask

  initial begin : main
    logic [10:0] bits;
    int bad, n;

    #1;
    chk("rst_outputs", {busy, done, error, ps2_clk_oe, ps2_data_oe}, 5'b00000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {busy, done, error, ps2_clk_oe, ps2_data_oe}, 5'b00000);

    // 0xED: data 1,0,1,1,0,1,1,1, parity 1, ACK
    start_tx("ed", 8'hED);
    dev_frame("ed", 0, 0, 1'b1, bits);
    chk("ed_byte", bits[8:1], 8'hED);
    chk("ed_parity", bits[9], 1);
    chk("ed_start_stop", {bits[10], bits[0]}, 2'b10);
    wait_end("ed", 1'b1, 1'b0);

    // 0xF4: parity 0, mid-frame request of 0x00 dropped, request in pulse cycle dropped
    start_tx("f4", 8'hF4);
    dev_frame("f4", 5, 0, 1'b1, bits);
    chk("f4_byte", bits[8:1], 8'hF4);
    chk("f4_parity", bits[9], 0);
    chk("f4_start_stop", {bits[10], bits[0]}, 2'b10);
    wait_end("f4", 1'b1, 1'b1);

    // 0x3C with NACK: parity 1, error only after lines idle
    start_tx("nack", 8'h3C);
    dev_frame("nack", 0, 0, 1'b0, bits);
    chk("nack_byte", bits[8:1], 8'h3C);
    chk("nack_parity", bits[9], 1);
    wait_end("nack", 1'b0, 1'b0);

    // Reset while bit 4 (a 0 bit of 0xED) is on the line
    start_tx("rst", 8'hED);
    dev_frame("rst", 0, 6, 1'b1, bits);
    repeat (5) @(negedge clk);
    chk("rst_recover_idle", {busy, done, error, ps2_clk_oe, ps2_data_oe}, 5'b00000);

    // 0x01 after reset: parity 0
    start_tx("one", 8'h01);
    dev_frame("one", 0, 0, 1'b1, bits);
    chk("one_byte", bits[8:1], 8'h01);
    chk("one_parity", bits[9], 0);
    chk("one_start_stop", {bits[10], bits[0]}, 2'b10);
    wait_end("one", 1'b1, 1'b0);

    // Device never clocks after RTS
    start_tx("stall", 8'hF4);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (!error && n < 5000) begin
      @(negedge clk); n++;
    end
    chk("stall_timeout_cycles", n, TMO);
    chk("stall_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(negedge clk);
    chk("stall_busy_after", busy, 0);
    chk("total_done", done_cnt, 3);
    chk("total_error", err_cnt, 2);
`else
    bad = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!(busy && ps2_data_oe && !ps2_clk_oe && !error && !done)) bad++;
    end
    chk("stall_hold_violations", bad, 0);
    chk("total_done", done_cnt, 3);
    chk("total_error", err_cnt, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
